// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side control for an 8N1, LSB-first UART.
// An external bit timer supplies shift_strobe at each data-bit centre and
// packet_done inside the stop bit. This block synchronises the line, detects
// start edges, shifts in data and manages the ready and error flags.
//
// Ports:
//   clk           - system clock, rising edge
//   n_Rst         - asynchronous active-low reset
//   serial_in     - asynchronous UART line, idle high
//   shift_strobe  - pulse at each data-bit centre (8 per frame)
//   packet_done   - pulse while the line is inside the stop bit
//   data_read     - consumer acknowledge pulse, clears data_ready
//   enable_timer  - run enable to the bit timer (decoded from state)
//   rx_data       - last accepted byte
//   data_ready    - rx_data holds an unread byte
//   framing_error - last frame had a stop bit of 0 (sticky)
//   overrun_error - an unread byte was overwritten (sticky)
module uart_rx_ctrl #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       n_Rst,
   input  logic       serial_in,
   input  logic       shift_strobe,
   input  logic       packet_done,
   input  logic       data_read,
   output logic       enable_timer,
   output logic [7:0] rx_data,
   output logic       data_ready,
   output logic       framing_error,
   output logic       overrun_error
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] RECEIVE  = 2'd1;
   localparam logic [1:0] ERR_WAIT = 2'd2;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sin_prev;
   logic [1:0]             r_state;
   logic [7:0]             r_shift;
   logic [7:0]             r_rx_data;
   logic                   r_data_ready;
   logic                   r_framing_error;
   logic                   r_overrun_error;

   logic       w_sin_s;
   logic       w_start;
   logic       w_load;
   logic       w_frame_err;
   logic [1:0] w_state_next;

   assign w_sin_s = r_sync[SYNC_STAGES-1];
   // Falling edge on the synchronised line; a held-low line never re-triggers.
   assign w_start = ~w_sin_s & r_sin_prev;

   assign w_load      = (r_state == RECEIVE) & packet_done & w_sin_s;
   assign w_frame_err = (r_state == RECEIVE) & packet_done & ~w_sin_s;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_start) w_state_next = RECEIVE;
         end
         RECEIVE: begin
            if (packet_done) w_state_next = w_sin_s ? IDLE : ERR_WAIT;
         end
         ERR_WAIT: begin
            if (w_sin_s) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Sync chain and previous sample reset high so reset looks like an idle line.
   always_ff @(posedge clk or negedge n_Rst) begin
      if (!n_Rst) begin
         r_sync     <= '1;
         r_sin_prev <= 1'b1;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], serial_in};
         r_sin_prev <= w_sin_s;
      end
   end

   always_ff @(posedge clk or negedge n_Rst) begin
      if (!n_Rst) begin
         r_state <= IDLE;
         r_shift <= 8'hFF;
      end else begin
         r_state <= w_state_next;
         // LSB arrives first, so after 8 right shifts it lands in bit 0.
         if ((r_state == RECEIVE) && shift_strobe) begin
            r_shift <= {w_sin_s, r_shift[7:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge n_Rst) begin
      if (!n_Rst) begin
         r_rx_data       <= 8'h00;
         r_data_ready    <= 1'b0;
         r_framing_error <= 1'b0;
         r_overrun_error <= 1'b0;
      end else begin
         if (w_load) begin
            r_rx_data    <= r_shift;
            r_data_ready <= 1'b1;
            // A simultaneous read consumed the old byte, so nothing was lost.
            if (r_data_ready && !data_read) r_overrun_error <= 1'b1;
         end else if (data_read) begin
            r_data_ready    <= 1'b0;
            r_overrun_error <= 1'b0;
         end

         if ((r_state == IDLE) && w_start) begin
            r_framing_error <= 1'b0;
         end else if (w_frame_err) begin
            r_framing_error <= 1'b1;
         end
      end
   end

   assign enable_timer  = (r_state == RECEIVE);
   assign rx_data       = r_rx_data;
   assign data_ready    = r_data_ready;
   assign framing_error = r_framing_error;
   assign overrun_error = r_overrun_error;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flops synchronising serial_in, minimum 2.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port n_Rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port serial_in  input  1  asynchronous UART line; idle high; 8N1, LSB first.
REQ-005 SHALL have port shift_strobe  input  1  one-cycle pulse from the bit timer at the centre of each of the 8 data bits.
REQ-006 SHALL have port packet_done  input  1  one-cycle pulse from the bit timer; the line is then inside the stop bit.
REQ-007 SHALL have port data_read  input  1  consumer acknowledge; a one-cycle pulse clears data_ready.
REQ-008 SHALL have port enable_timer  output  1  run enable to the bit timer.
REQ-009 SHALL have port rx_data  output  8  last accepted byte.
REQ-010 SHALL have port data_ready  output  1  rx_data holds an unread byte.
REQ-011 SHALL have port framing_error  output  1  last frame had a stop bit of 0.
REQ-012 SHALL have port overrun_error  output  1  an unread byte was overwritten.

Function
REQ-013 SHALL pass serial_in through SYNC_STAGES flops and use only the synchronised value (sin_s) internally.
REQ-014 SHALL detect a start edge as sin_s=0 with its previous registered value =1.
REQ-015 SHALL implement the FSM states IDLE, RECEIVE and ERR_WAIT.
REQ-016 IDLE: enable_timer=0; on a start edge, go to RECEIVE at the next edge and clear framing_error at that same edge.
REQ-017 RECEIVE: enable_timer=1; on each shift_strobe, shift the 8-bit shift register right with sin_s entering bit 7; after 8 strobes, the first data bit sits in bit 0.
REQ-018 RECEIVE with packet_done=1 and sin_s=1: at that edge, copy the shift register to rx_data, set data_ready, and go to IDLE.
REQ-019 RECEIVE with packet_done=1 and sin_s=0: at that edge, set framing_error, leave rx_data and data_ready unchanged, and go to ERR_WAIT.
REQ-020 ERR_WAIT: enable_timer=0; stay until sin_s=1, then go to IDLE; a line held low (break) SHALL NOT start a frame.
REQ-021 Latency: rx_data and data_ready SHALL be valid in the cycle after the packet_done cycle.
REQ-022 data_read=1 with no load in the same cycle SHALL clear data_ready and overrun_error at the next edge.
REQ-023 A load while data_ready=1 and data_read=0 SHALL overwrite rx_data, keep data_ready=1 and set overrun_error.
REQ-024 A load and data_read=1 in the same cycle SHALL take rx_data = new byte, data_ready=1, and leave overrun_error unchanged.
REQ-025 overrun_error and framing_error SHALL be sticky until their clearing event.
REQ-026 shift_strobe outside RECEIVE SHALL be ignored.
REQ-027 A start edge in any state other than IDLE SHALL be ignored.
REQ-028 All outputs SHALL be registered, except enable_timer, which is decoded from state.

Reset
REQ-029 n_Rst=0 SHALL immediately force: state IDLE; sync flops and previous-sample flop to 1; shift register 8'hFF; rx_data 8'h00; data_ready, framing_error, overrun_error, enable_timer all 0.
REQ-030 Reset mid-frame SHALL discard the partial byte; after release, no frame starts until a new 1->0 transition occurs on sin_s.

Verification
REQ-031 Send 0x55 with stop bit 1 and cyclewaits=434 timer -> one cycle after packet_done: rx_data=8'h55, data_ready=1, errors 0.
REQ-032 Send 0xA3, then pulse data_read -> data_ready=0 next cycle; then send 0x0F without reading -> rx_data=8'h0F; then send 0xF0 without reading -> rx_data=8'hF0, overrun_error=1.
REQ-033 Send 0x3C with stop bit 0 -> framing_error=1, rx_data and data_ready unchanged, FSM in ERR_WAIT until line high; next valid frame 0x81 -> framing_error=0, rx_data=8'h81.
REQ-034 Hold the line low for 30 bit times after a framing error -> no further load; enable_timer=0 throughout.
REQ-035 Pulse data_read in the same cycle as the load of 0x7E while data_ready=1 -> data_ready=1, rx_data=8'h7E, overrun_error unchanged.
REQ-036 Assert n_Rst after the 4th shift_strobe of a frame -> all outputs at reset values; next full frame 0xC6 -> rx_data=8'hC6.
